// File: rtl/safety_island_boot_pkg.sv
// Shared types and register map for the safety island hardware boot sequencer.
// Used by safety_island_boot_ctrl (optional timeout: SAFETY_ISLAND_BOOT_TIMEOUT_EN).
package safety_island_boot_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MODE   = 3'd1,
        WR_ENTRY  = 3'd2,
        WR_FETCH  = 3'd3,
        POLL_WAIT = 3'd4,
        RD_STATUS = 3'd5,
        DONE      = 3'd6,
        FAIL      = 3'd7
    } boot_state_e;

    // SoC-control register byte offsets from the control base address
    localparam logic [31:0] OffsEntry  = 32'h0000_0000;
    localparam logic [31:0] OffsFetch  = 32'h0000_0004;
    localparam logic [31:0] OffsMode   = 32'h0000_0008;
    localparam logic [31:0] OffsStatus = 32'h0000_000C;

    localparam int          EocBit            = 31;
    localparam logic [31:0] BootModePreloaded = 32'h0000_0001;
    localparam logic [31:0] FetchEnableVal    = 32'h0000_0001;

endpackage

// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer: writes bootmode, entry point and fetch enable, then polls STATUS until EOC.
// Define SAFETY_ISLAND_BOOT_TIMEOUT_EN to fail after TimeoutPolls status reads without EOC.
module safety_island_boot_ctrl
    import safety_island_boot_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter logic [AddrWidth-1:0] CtrlBaseAddr = AddrWidth'(32'h0020_0000),
    parameter int unsigned          PollInterval = 1024,
    parameter int unsigned          TimeoutPolls = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DataWidth-1:0] bootmode_i,
    input  logic [DataWidth-1:0] entry_point_i,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 we_o,
    output logic [3:0]           be_o,
    output logic [DataWidth-1:0] wdata_o,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    input  logic                 err_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DataWidth-2:0] exit_status_o,
    output logic                 error_o,
    output boot_state_e          state_o
);

    // Bus handshake: req_o is held with addr/we/wdata stable until the gnt_i cycle,
    // drops the next cycle, and the FSM only advances on the matching rvalid_i.
    localparam int unsigned    IntW         = (PollInterval > 1) ? $clog2(PollInterval) : 1;
    localparam logic [IntW-1:0] IntervalLoad = IntW'(PollInterval - 1);

    boot_state_e          state_q, state_d;
    logic                 granted_q, granted_d;
    logic [IntW-1:0]      interval_q, interval_d;
    logic [DataWidth-2:0] exit_q, exit_d;
    logic [DataWidth-1:0] bootmode_q, entry_q;
    logic                 access, rsp, start_ok, timeout_hit;

    function automatic logic [AddrWidth-1:0] reg_addr(input logic [31:0] offs);
        return CtrlBaseAddr + AddrWidth'(offs);
    endfunction

    assign access   = (state_q inside {WR_MODE, WR_ENTRY, WR_FETCH, RD_STATUS});
    assign rsp      = access && granted_q && rvalid_i;
    assign start_ok = start_i && (state_q inside {IDLE, DONE, FAIL});

`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
    localparam int unsigned PcW = $clog2(TimeoutPolls + 1);
    logic [PcW-1:0] polls_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            polls_q <= '0;
        end else if (start_ok) begin
            polls_q <= '0;
        end else if (rsp && (state_q == RD_STATUS)) begin
            polls_q <= polls_q + PcW'(1);
        end
    end

    // True while the read in flight is the last one allowed
    assign timeout_hit = (polls_q == PcW'(TimeoutPolls - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            granted_q  <= 1'b0;
            interval_q <= '0;
            exit_q     <= '0;
            bootmode_q <= '0;
            entry_q    <= '0;
        end else begin
            state_q    <= state_d;
            granted_q  <= granted_d;
            interval_q <= interval_d;
            exit_q     <= exit_d;
            if (start_ok) begin
                bootmode_q <= bootmode_i;
                entry_q    <= entry_point_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        granted_d  = granted_q;
        interval_d = interval_q;
        exit_d     = exit_q;
        req_o      = 1'b0;
        we_o       = 1'b0;
        addr_o     = '0;
        wdata_o    = '0;

        case (state_q)
            WR_MODE: begin
                req_o   = !granted_q;
                we_o    = 1'b1;
                addr_o  = reg_addr(OffsMode);
                wdata_o = bootmode_q;
            end
            WR_ENTRY: begin
                req_o   = !granted_q;
                we_o    = 1'b1;
                addr_o  = reg_addr(OffsEntry);
                wdata_o = entry_q;
            end
            WR_FETCH: begin
                req_o   = !granted_q;
                we_o    = 1'b1;
                addr_o  = reg_addr(OffsFetch);
                wdata_o = DataWidth'(FetchEnableVal);
            end
            RD_STATUS: begin
                req_o  = !granted_q;
                addr_o = reg_addr(OffsStatus);
            end
            POLL_WAIT: begin
                if (interval_q == '0) state_d = RD_STATUS;
                else                  interval_d = interval_q - IntW'(1);
            end
            default: ;
        endcase

        if (req_o && gnt_i) granted_d = 1'b1;

        if (rsp) begin
            granted_d = 1'b0;
            if (err_i) begin
                state_d = FAIL;
            end else begin
                case (state_q)
                    WR_MODE:  state_d = WR_ENTRY;
                    WR_ENTRY: state_d = WR_FETCH;
                    WR_FETCH: begin
                        state_d    = POLL_WAIT;
                        interval_d = IntervalLoad;
                    end
                    RD_STATUS: begin
                        if (rdata_i[EocBit]) begin
                            exit_d  = rdata_i[EocBit-1:0];
                            state_d = DONE;
                        end else if (timeout_hit) begin
                            state_d = FAIL;
                        end else begin
                            state_d    = POLL_WAIT;
                            interval_d = IntervalLoad;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (start_ok) begin
            state_d   = WR_MODE;
            granted_d = 1'b0;
            exit_d    = '0;
        end
    end

    assign be_o          = 4'hF;
    assign busy_o        = !(state_q inside {IDLE, DONE, FAIL});
    assign done_o        = (state_q == DONE);
    assign error_o       = (state_q == FAIL);
    assign exit_status_o = exit_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Randomized bench for safety_island_boot_ctrl: bus slave with random latencies and a
// transaction-list reference model derived from the boot sequence rules.
module tb_safety_island_boot_ctrl;
    import safety_island_boot_pkg::*;

    localparam int          PollInt = 6;
    localparam int          ToPolls = 4;
    localparam logic [31:0] Base    = 32'h0020_0000;

    logic        clk, rst_n, start_i;
    logic [31:0] bootmode_i, entry_point_i;
    logic        req_o, gnt_i, we_o, rvalid_i, err_i;
    logic [31:0] addr_o, wdata_o, rdata_i;
    logic [3:0]  be_o;
    logic        busy_o, done_o, error_o;
    logic [30:0] exit_status_o;
    boot_state_e state_o;

    safety_island_boot_ctrl #(
        .AddrWidth(32), .DataWidth(32), .CtrlBaseAddr(Base),
        .PollInterval(PollInt), .TimeoutPolls(ToPolls)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .bootmode_i(bootmode_i),
        .entry_point_i(entry_point_i), .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o),
        .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .err_i(err_i), .busy_o(busy_o), .done_o(done_o), .exit_status_o(exit_status_o),
        .error_o(error_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- bus slave + transaction log ----------------
    int          gnt_min = 0, gnt_max = 0, rv_max = 0;
    int          eoc_read = 0;      // 1-based status read that returns EOC, 0 = never
    int          err_idx = -1;      // transaction index answered with err_i
    bit          stall_reads = 0;   // never grant status reads
    logic [31:0] eoc_val;
    int          rd_no = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] log_we[$];
    int          log_req_cyc[$];
    int          log_rv_cyc[$];

    int          phase = 0, gcnt = 0, rcnt = 0;
    logic [31:0] cur_addr, cur_data;
    logic        cur_we;

    task automatic try_grant();
        if (!(stall_reads && !cur_we) && gcnt == 0) begin
            gnt_i = 1'b1;
            phase = 2;
            rcnt  = $urandom_range(0, rv_max);
        end else if (gcnt > 0) begin
            gcnt--;
        end
    endtask

    initial begin
        gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
        forever begin
            @(negedge clk);
            gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
            if (!rst_n) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (req_o) begin
                        cur_addr = addr_o; cur_data = wdata_o; cur_we = we_o;
                        log_addr.push_back(addr_o);
                        log_data.push_back(wdata_o);
                        log_we.push_back({31'd0, we_o});
                        log_req_cyc.push_back(cyc);
                        gcnt  = $urandom_range(gnt_min, gnt_max);
                        phase = 1;
                        try_grant();
                    end
                    1: begin
                        check_eq("req_held", {31'd0, req_o}, 32'd1);
                        check_eq("addr_stable", addr_o, cur_addr);
                        check_eq("we_stable", {31'd0, we_o}, {31'd0, cur_we});
                        if (cur_we) check_eq("wdata_stable", wdata_o, cur_data);
                        try_grant();
                    end
                    default: begin
                        check_eq("no_req_outstanding", {31'd0, req_o}, 32'd0);
                        if (rcnt == 0) begin
                            rvalid_i = 1'b1;
                            err_i    = ((log_addr.size() - 1) == err_idx);
                            if (!cur_we) begin
                                rd_no++;
                                if (rd_no == eoc_read) rdata_i = eoc_val;
                                else                   rdata_i = $urandom() & 32'h7FFF_FFFF;
                            end
                            log_rv_cyc.push_back(cyc);
                            phase = 0;
                        end else begin
                            rcnt--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_we.delete();
        log_req_cyc.delete(); log_rv_cyc.delete();
        rd_no = 0;
    endtask

    // ---------------- reference model + one boot run ----------------
    task automatic run_boot(input logic [31:0] bm, input logic [31:0] ep, input int eoc_n,
                            input logic [31:0] eoc_data, input int err_at,
                            input int gmin, input int gmax, input int rmax, input bit extra_start);
        logic [31:0] exp_q[$];
        logic [31:0] exp_d_q[$];
        logic [31:0] exp_we_q[$];
        int  reads, n, st_cyc;
        bit  to_fail, exp_done, exp_err;
        logic [31:0] exp_exit;

        gnt_min = gmin; gnt_max = gmax; rv_max = rmax;
        eoc_read = eoc_n; eoc_val = eoc_data; err_idx = err_at; stall_reads = 0;
        clear_log();

        to_fail = 0;
        reads   = eoc_n;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
        if (eoc_n == 0 || eoc_n > ToPolls) begin
            reads   = ToPolls;
            to_fail = 1;
        end
`endif
        exp_q.push_back(Base + 32'h8); exp_d_q.push_back(bm);    exp_we_q.push_back(1);
        exp_q.push_back(Base + 32'h0); exp_d_q.push_back(ep);    exp_we_q.push_back(1);
        exp_q.push_back(Base + 32'h4); exp_d_q.push_back(32'h1); exp_we_q.push_back(1);
        for (int i = 0; i < reads; i++) begin
            exp_q.push_back(Base + 32'hC); exp_d_q.push_back(32'h0); exp_we_q.push_back(0);
        end
        if (err_at >= 0) begin
            while (exp_q.size() > err_at + 1) begin
                void'(exp_q.pop_back()); void'(exp_d_q.pop_back()); void'(exp_we_q.pop_back());
            end
            exp_err = 1; exp_done = 0;
        end else begin
            exp_err = to_fail; exp_done = !to_fail;
        end
        exp_exit = exp_done ? (eoc_data & 32'h7FFF_FFFF) : 32'h0;

        @(negedge clk);
        start_i = 1'b1; bootmode_i = bm; entry_point_i = ep; st_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0; bootmode_i = $urandom(); entry_point_i = $urandom();
        check_eq("busy_after_start", {31'd0, busy_o}, 32'd1);
        check_eq("done_cleared", {31'd0, done_o}, 32'd0);
        check_eq("error_cleared", {31'd0, error_o}, 32'd0);
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end

        n = 0;
        while (!(done_o || error_o) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("run_completes", {31'd0, done_o || error_o}, 32'd1);

        check_eq("txn_count", log_addr.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
            check_eq("txn_addr", log_addr[i], exp_q[i]);
            check_eq("txn_we", log_we[i], exp_we_q[i]);
            if (exp_we_q[i] == 1) check_eq("txn_wdata", log_data[i], exp_d_q[i]);
            if (i >= 3 && i < log_req_cyc.size() && (i - 1) < log_rv_cyc.size())
                check_eq("poll_spacing", log_req_cyc[i] - log_rv_cyc[i-1], PollInt + 1);
        end
        if (log_req_cyc.size() > 0 && !extra_start)
            check_eq("start_to_req", log_req_cyc[0] - st_cyc, 1);
        check_eq("done", {31'd0, done_o}, {31'd0, exp_done});
        check_eq("error", {31'd0, error_o}, {31'd0, exp_err});
        check_eq("exit_status", {1'b0, exit_status_o}, exp_exit);
        check_eq("busy_idle", {31'd0, busy_o}, 32'd0);
        check_eq("be", {28'd0, be_o}, 32'hF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, {31'd0, req_o}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, we_o}, 32'd0);
        check_eq({tag, "_addr"}, addr_o, 32'd0);
        check_eq({tag, "_wdata"}, wdata_o, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check_eq({tag, "_error"}, {31'd0, error_o}, 32'd0);
        check_eq({tag, "_exit"}, {1'b0, exit_status_o}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, lim, eoc_n, err_at;
        logic [31:0] r;
        rst_n = 1'b0; start_i = 1'b0; bootmode_i = '0; entry_point_i = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_boot(BootModePreloaded, 32'h1C00_8080, 3, 32'h8000_0000, -1, 0, 0, 0, 0);
        run_boot(32'h0000_0002, 32'h1C00_0000, 2, 32'h8000_0055, -1, 5, 5, 4, 0);
        run_boot(BootModePreloaded, 32'h1C00_8080, 3, 32'h8000_0000, 1, 0, 2, 2, 0);
        run_boot(BootModePreloaded, 32'h1C00_8080, 1, 32'hFFFF_FFFF, -1, 0, 1, 1, 0);

        // reset while a status read is pending
        clear_log();
        gnt_min = 0; gnt_max = 0; rv_max = 0; eoc_read = 0; err_idx = -1; stall_reads = 1;
        @(negedge clk);
        start_i = 1'b1; bootmode_i = 32'h1; entry_point_i = 32'h1C00_8080;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (log_addr.size() < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reached_status_read", {31'd0, log_addr.size() >= 4}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        check_eq("mid_reset_state", 32'(state_o), 32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall_reads = 0;
        run_boot(BootModePreloaded, 32'h1C00_8080, 2, 32'h8000_0007, -1, 0, 0, 0, 0);

`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
        lim = ToPolls;
        run_boot(BootModePreloaded, 32'h1C00_8080, 0, 32'h8000_0000, -1, 0, 1, 1, 0);
`else
        lim = 5;
`endif
        for (int t = 0; t < 8; t++) begin
            eoc_n  = $urandom_range(1, lim);
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 + eoc_n)) : -1;
            r      = $urandom();
            run_boot($urandom(), $urandom(), eoc_n, r | 32'h8000_0000, err_at,
                     0, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
